// File: rtl/exp6_detector_jogada.sv
// Button conditioner: 2-FF sync, debounce FSM and press edge detection for the game datapath.
// Optional macro ONEHOT_CHECK_EN rejects multi-button presses and reports them on erro_multipla.
module exp6_detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CW              = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes,
    input  logic       enable,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       tem_jogada,
    output logic       erro_multipla,
    output logic [3:0] db_estado
);

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        FILTRA_PRESS = 2'd1,
        PRESSIONADO  = 2'd2,
        FILTRA_SOLTA = 2'd3
    } estado_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    estado_t       state_q, state_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    jogada_q, jogada_d;
    logic          feita_q;
    logic          cnt_last, aceita, rejeita, grava;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= botoes;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= OCIOSO;
        else       state_q <= state_d;
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    // enable is checked before the count so a disable always cancels a pending press
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:
                if (sync2_q != 4'd0 && enable) state_d = FILTRA_PRESS;
            FILTRA_PRESS:
                if (sync2_q != cand_q || !enable) state_d = OCIOSO;
                else if (cnt_last)                 state_d = PRESSIONADO;
            PRESSIONADO:
                if (sync2_q == 4'd0) state_d = FILTRA_SOLTA;
            FILTRA_SOLTA:
                if (sync2_q != 4'd0) state_d = PRESSIONADO;
                else if (cnt_last)   state_d = OCIOSO;
            default:
                state_d = OCIOSO;
        endcase
    end

    always_comb begin
        tem_jogada = (state_q == PRESSIONADO) || (state_q == FILTRA_SOLTA);
        db_estado  = {2'b00, state_q};
        aceita     = (state_q == FILTRA_PRESS) && (state_d == PRESSIONADO);
    end

`ifdef ONEHOT_CHECK_EN
    logic erro_q;
    // a multi-bit code still enters PRESSIONADO so the held combo cannot retrigger
    assign rejeita = aceita && ((cand_q & (cand_q - 4'd1)) != 4'd0);

    always_ff @(posedge clock) begin
        if (reset) erro_q <= 1'b0;
        else       erro_q <= rejeita;
    end
    assign erro_multipla = erro_q;
`else
    assign rejeita       = 1'b0;
    assign erro_multipla = 1'b0;
`endif

    assign grava = aceita && !rejeita;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        jogada_d = jogada_q;
        case (state_q)
            OCIOSO: begin
                cand_d = sync2_q;
                cnt_d  = '0;
            end
            PRESSIONADO:
                cnt_d = '0;
            default:
                if (state_d == state_q) cnt_d = cnt_q + CW'(1);
        endcase
        if (grava) jogada_d = cand_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cand_q   <= '0;
            cnt_q    <= '0;
            jogada_q <= '0;
            feita_q  <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            jogada_q <= jogada_d;
            feita_q  <= grava;
        end
    end

    assign jogada       = jogada_q;
    assign jogada_feita = feita_q;

endmodule

// File: tb/tb_exp6_detector_jogada.sv
// Directed bench for exp6_detector_jogada with DEBOUNCE_CYCLES=4 (press latency 7 edges).
module tb_exp6_detector_jogada;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] botoes = 4'h0;
    logic       enable = 1'b0;
    logic [3:0] jogada;
    logic       jogada_feita, tem_jogada, erro_multipla;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef ONEHOT_CHECK_EN
    localparam bit OH = 1'b1;
`else
    localparam bit OH = 1'b0;
`endif

    exp6_detector_jogada #(.DEBOUNCE_CYCLES(4), .CW(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .enable       (enable),
        .jogada       (jogada),
        .jogada_feita (jogada_feita),
        .tem_jogada   (tem_jogada),
        .erro_multipla(erro_multipla),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst;
        logic       en;
        logic [3:0] b;
        int         n;
        logic [3:0] ej;
        logic       ef;
        logic       et;
        logic       ee;
        logic [3:0] es;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm, input logic rst, input logic en, input logic [3:0] b,
                       input int n, input logic [3:0] ej, input logic ef, input logic et,
                       input logic ee, input logic [3:0] es);
        vec_t v;
        v.name = nm; v.rst = rst; v.en = en; v.b = b; v.n = n;
        v.ej = ej; v.ef = ef; v.et = et; v.ee = ee; v.es = es;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    initial begin
        logic [3:0] j3;
        int pulses, first_at, erros, steps;
        j3 = OH ? 4'h0 : 4'h3;

        //   name           rst en b     n   jog  f  t  e  est
        add("rst_hold",     1, 0, 4'h8, 2,  4'h0, 0, 0, 0, 4'd0);
        add("rst_rel",      0, 0, 4'h8, 1,  4'h0, 0, 0, 0, 4'd0);
        add("rst_flush",    0, 0, 4'h0, 3,  4'h0, 0, 0, 0, 4'd0);
        add("p4_sync",      0, 1, 4'h4, 3,  4'h0, 0, 0, 0, 4'd1);
        add("p4_cnt",       0, 1, 4'h4, 3,  4'h0, 0, 0, 0, 4'd1);
        add("p4_acc",       0, 1, 4'h4, 1,  4'h4, 1, 1, 0, 4'd2);
        add("p4_pulse_end", 0, 1, 4'h4, 1,  4'h4, 0, 1, 0, 4'd2);
        add("p4_hold",      0, 1, 4'h4, 12, 4'h4, 0, 1, 0, 4'd2);
        add("r4_filt",      0, 1, 4'h0, 6,  4'h4, 0, 1, 0, 4'd3);
        add("r4_done",      0, 1, 4'h0, 1,  4'h4, 0, 0, 0, 4'd0);
        add("g1_a",         0, 1, 4'h1, 2,  4'h4, 0, 0, 0, 4'd0);
        add("g1_b",         0, 1, 4'h0, 1,  4'h4, 0, 0, 0, 4'd1);
        add("g1_c",         0, 1, 4'h0, 1,  4'h4, 0, 0, 0, 4'd1);
        add("g1_d",         0, 1, 4'h0, 1,  4'h4, 0, 0, 0, 4'd0);
        add("g1_e",         0, 1, 4'h0, 2,  4'h4, 0, 0, 0, 4'd0);
        add("b_acc",        0, 1, 4'h4, 7,  4'h4, 1, 1, 0, 4'd2);
        add("b_rel",        0, 1, 4'h0, 2,  4'h4, 0, 1, 0, 4'd2);
        add("b_bnc_a",      0, 1, 4'h4, 1,  4'h4, 0, 1, 0, 4'd3);
        add("b_bnc_b",      0, 1, 4'h4, 1,  4'h4, 0, 1, 0, 4'd3);
        add("b_bnc_c",      0, 1, 4'h4, 1,  4'h4, 0, 1, 0, 4'd2);
        add("b_hold",       0, 1, 4'h4, 3,  4'h4, 0, 1, 0, 4'd2);
        add("b_rel2",       0, 1, 4'h0, 7,  4'h4, 0, 0, 0, 4'd0);
        add("dis_hold",     0, 0, 4'h2, 6,  4'h4, 0, 0, 0, 4'd0);
        add("dis_en",       0, 1, 4'h2, 1,  4'h4, 0, 0, 0, 4'd1);
        add("dis_drop",     0, 0, 4'h2, 1,  4'h4, 0, 0, 0, 4'd0);
        add("dis_stay",     0, 0, 4'h2, 5,  4'h4, 0, 0, 0, 4'd0);
        add("prec_cnt",     0, 1, 4'h2, 4,  4'h4, 0, 0, 0, 4'd1);
        add("prec_drop",    0, 0, 4'h2, 1,  4'h4, 0, 0, 0, 4'd0);
        add("prec_after",   0, 0, 4'h2, 1,  4'h4, 0, 0, 0, 4'd0);
        add("dis_rel",      0, 0, 4'h0, 3,  4'h4, 0, 0, 0, 4'd0);
        add("p8_acc",       0, 1, 4'h8, 7,  4'h8, 1, 1, 0, 4'd2);
        add("rst_mid",      1, 1, 4'h8, 1,  4'h0, 0, 0, 0, 4'd0);
        add("rst_mid_rel",  0, 1, 4'h0, 3,  4'h0, 0, 0, 0, 4'd0);
        add("p3_acc",       0, 1, 4'h3, 7,  j3,   !OH, 1, OH, 4'd2);
        add("p3_after",     0, 1, 4'h3, 1,  j3,   0, 1, 0, 4'd2);
        add("p3_hold",      0, 1, 4'h3, 12, j3,   0, 1, 0, 4'd2);
        add("p3_rel",       0, 1, 4'h0, 7,  j3,   0, 0, 0, 4'd0);
        add("p1_acc",       0, 1, 4'h1, 7,  4'h1, 1, 1, 0, 4'd2);
        add("p1_rel",       0, 1, 4'h0, 7,  4'h1, 0, 0, 0, 4'd0);

        foreach (vq[i]) begin
            reset  = vq[i].rst;
            enable = vq[i].en;
            botoes = vq[i].b;
            repeat (vq[i].n) tick();
            chk({vq[i].name, ".jogada"},        32'(jogada),        32'(vq[i].ej));
            chk({vq[i].name, ".jogada_feita"},  32'(jogada_feita),  32'(vq[i].ef));
            chk({vq[i].name, ".tem_jogada"},    32'(tem_jogada),    32'(vq[i].et));
            chk({vq[i].name, ".erro_multipla"}, 32'(erro_multipla), 32'(vq[i].ee));
            chk({vq[i].name, ".db_estado"},     32'(db_estado),     32'(vq[i].es));
        end

        // full press: exactly one pulse, landing on the 7th edge, across a 20-cycle hold
        reset = 1'b0; enable = 1'b1; botoes = 4'h2;
        pulses = 0; first_at = -1; erros = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (jogada_feita) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
            if (erro_multipla) erros++;
        end
        chk("seq.pulse_count", 32'(pulses), 32'd1);
        chk("seq.pulse_edge",  32'(first_at), 32'd7);
        chk("seq.erro_count",  32'(erros), 32'd0);
        chk("seq.jogada",      32'(jogada), 32'h2);

        // release: tem_jogada must fall exactly 7 edges after botoes returns to 0
        botoes = 4'h0;
        steps = 0;
        while (tem_jogada && steps < 20) begin
            tick();
            steps++;
        end
        chk("seq.release_edges", 32'(steps), 32'd7);
        chk("seq.release_state", 32'(db_estado), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
